usr_sw_debounce: RTL

- Input-side companion to the board LED/debug outputs. Samples the asynchronous DIP-switch bus (usr_sw) and produces a debounced switch state for control logic.
- Records which switches changed as write-1-to-clear sticky bits and raises an interrupt.
- Emits change events over a valid/ready handshake.
- Sits in the FPGA top, in the 200 MHz domain, between the usr_sw pins and the control-plane register logic.

---
 rtl/usr_sw_debounce.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/usr_sw_debounce.sv
// ---------------------------------------------------------------------------
// usr_sw_debounce: DIP-switch synchronizer/debouncer with sticky change flags,
// irq and a merging valid/ready change event. Option: USR_SW_GLITCH_CNT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module usr_sw_debounce #(
  parameter int WIDTH          = 8,
  parameter int TICK_DIV       = 200,
  parameter int DEBOUNCE_TICKS = 5000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] usr_sw_i,
  output logic [WIDTH-1:0] sw_state,
  output logic [WIDTH-1:0] sw_changed,
  input  logic [WIDTH-1:0] chg_clr,
  output logic             irq,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [WIDTH-1:0] ev_state,
  output logic [WIDTH-1:0] ev_mask,
  output logic [31:0]      debug
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   init_cnt_q, init_cnt_d;
  logic [WIDTH-1:0]             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [PRE_W-1:0]             presc_q, presc_d;
  logic [WIDTH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]             sw_state_q, sw_state_d;
  logic [WIDTH-1:0]             sw_changed_q, sw_changed_d;
  logic                         irq_q, irq_d;
  logic                         ev_valid_q, ev_valid_d;
  logic [WIDTH-1:0]             ev_state_q, ev_state_d;
  logic [WIDTH-1:0]             ev_mask_q, ev_mask_d;
  logic [15:0]                  ev_count_q, ev_count_d;
  logic [7:0]                   merge_cnt_q, merge_cnt_d;
  logic                         tick;
  logic [WIDTH-1:0]             settle;
  logic [WIDTH-1:0]             aborted;
`ifdef USR_SW_GLITCH_CNT_EN
  logic [15:0]                  glitch_q, glitch_d;
`endif

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    sync1_d      = usr_sw_i;
    sync2_d      = sync1_q;
    cnt_d        = cnt_q;
    sw_state_d   = sw_state_q;
    ev_valid_d   = ev_valid_q;
    ev_state_d   = ev_state_q;
    ev_mask_d    = ev_mask_q;
    merge_cnt_d  = merge_cnt_q;
    settle       = '0;
    aborted      = '0;

    tick    = (presc_q == PRE_MAX);
    presc_d = tick ? '0 : presc_q + 1'b1;

    if (state_q == ST_INIT) begin
      cnt_d = '0;
      if (init_cnt_q == 2'd2) begin
        // Initial levels are adopted silently: no sticky bit, no event.
        sw_state_d = sync2_q;
        state_d    = ST_RUN;
      end else begin
        init_cnt_d = init_cnt_q + 2'd1;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == sw_state_q[i]) begin
          cnt_d[i]   = '0;
          aborted[i] = (cnt_q[i] != '0);
        end else if (tick) begin
          if (cnt_q[i] == CNT_MAX) begin
            sw_state_d[i] = sync2_q[i];
            cnt_d[i]      = '0;
            settle[i]     = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      end
    end

    sw_changed_d = (sw_changed_q & ~chg_clr) | settle;
    irq_d        = |sw_changed_q;
    ev_count_d   = ev_count_q + {15'd0, (ev_valid_q && ev_ready)};

    if (settle != '0) begin
      ev_valid_d = 1'b1;
      ev_state_d = sw_state_d;
      if (!ev_valid_q || ev_ready) begin
        ev_mask_d = settle;
      end else begin
        // Consumer stalled: fold the new change into the pending event.
        ev_mask_d = ev_mask_q | settle;
        if (merge_cnt_q != 8'hFF) merge_cnt_d = merge_cnt_q + 8'd1;
      end
    end else if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
      ev_mask_d  = '0;
    end

`ifdef USR_SW_GLITCH_CNT_EN
    glitch_d = glitch_q;
    if ((aborted != '0) && (glitch_q != 16'hFFFF)) glitch_d = glitch_q + 16'd1;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      presc_q      <= '0;
      cnt_q        <= '0;
      sw_state_q   <= '0;
      sw_changed_q <= '0;
      irq_q        <= 1'b0;
      ev_valid_q   <= 1'b0;
      ev_state_q   <= '0;
      ev_mask_q    <= '0;
      ev_count_q   <= '0;
      merge_cnt_q  <= '0;
`ifdef USR_SW_GLITCH_CNT_EN
      glitch_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      sw_state_q   <= sw_state_d;
      sw_changed_q <= sw_changed_d;
      irq_q        <= irq_d;
      ev_valid_q   <= ev_valid_d;
      ev_state_q   <= ev_state_d;
      ev_mask_q    <= ev_mask_d;
      ev_count_q   <= ev_count_d;
      merge_cnt_q  <= merge_cnt_d;
`ifdef USR_SW_GLITCH_CNT_EN
      glitch_q     <= glitch_d;
`endif
    end
  end

  assign sw_state   = sw_state_q;
  assign sw_changed = sw_changed_q;
  assign irq        = irq_q;
  assign ev_valid   = ev_valid_q;
  assign ev_state   = ev_state_q;
  assign ev_mask    = ev_mask_q;

`ifdef USR_SW_GLITCH_CNT_EN
  assign debug = {glitch_q, merge_cnt_q, ev_count_q[7:0]};
`else
  assign debug = {16'h0000, merge_cnt_q, ev_count_q[7:0]};
`endif

  // Upper event-count bits and abort flags are not exported in every build.
  logic unused_ok;
  assign unused_ok = ^{ev_count_q[15:8], aborted};

endmodule

`default_nettype wire
